regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_pkg.sv | 13 +
 rtl/regfile_wb_arbiter_if.sv | 28 ++
 rtl/regfile_wb_arbiter_rr_arb2.sv | 15 +
 rtl/regfile_wb_arbiter.sv | 78 +++++++
 tb/tb_regfile_wb_arbiter.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared core definitions for the register-file writeback path: default widths
// and the INIT/RUN state encoding used by the arbiter.
package regfile_wb_arbiter_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus: the ALU (req0) and load unit (req1) each present
// valid/addr/data and receive a same-cycle ready from the arbiter.
interface regfile_wb_arbiter_if #(
    parameter int DATA_WIDTH = regfile_wb_arbiter_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = regfile_wb_arbiter_pkg::ADDR_WIDTH
);
    logic                  req0_valid;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_data;
    logic                  req0_ready;

    logic                  req1_valid;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_data;
    logic                  req1_ready;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready
    );
endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins outright; under contention
// the requester that did not win last time is granted.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);
    always_comb begin
        // NOTE: gnt gets a value on every path before any condition so no latch is inferred.
        gnt = req;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: clears registers 1..N-1 after reset, then
// round-robins the ALU and load writeback ports onto a single write port.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = regfile_wb_arbiter_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = regfile_wb_arbiter_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_wb_arbiter_if.slave   bus,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  init_done
);
    import regfile_wb_arbiter_pkg::*;

    state_t                state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic                  last_grant;
    logic [1:0]            req;
    logic [1:0]            gnt;
    logic                  run;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    assign run = (state == RUN);
    assign req = {bus.req1_valid, bus.req0_valid};

    rr_arb2 u_arb (
        .req  (req),
        .last (last_grant),
        .gnt  (gnt)
    );

    // gnt is already qualified by valid, so ready only needs gating by RUN.
    assign bus.req0_ready = run & gnt[0];
    assign bus.req1_ready = run & gnt[1];
    assign accept         = run & (|gnt);
    assign sel_addr       = gnt[1] ? bus.req1_addr : bus.req0_addr;
    assign sel_data       = gnt[1] ? bus.req1_data : bus.req0_data;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= INIT;
            ptr        <= ADDR_WIDTH'(1);
            last_grant <= 1'b1;
            rf_wen     <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            init_done  <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    rf_wen   <= 1'b1;
                    rf_waddr <= ptr;
                    rf_wdata <= '0;
                    ptr      <= ptr + 1'b1;
                    if (ptr == '1) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end
                end
                RUN: begin
                    // Register 0 is hardwired: the write is accepted but suppressed.
                    rf_wen <= accept && (sel_addr != '0);
                    if (accept) begin
                        rf_waddr   <= sel_addr;
                        rf_wdata   <= sel_data;
                        last_grant <= gnt[1];
                    end
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: the driver pushes expected writes into
// a queue and a monitor compares them one edge later.
module tb_regfile_wb_arbiter;

    typedef struct {
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        done;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        init_done;

    int   vectors;
    int   miscompares;
    exp_t exp_q[$];

    regfile_wb_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    regfile_wb_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a falling edge: drives the requests, checks the readies, queues
    // the write expected after the next rising edge, and returns at the next falling edge.
    task automatic step(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                        input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                        input logic er0, input logic er1, input logic push, input exp_t e);
        bus.req0_valid = v0;
        bus.req0_addr  = a0;
        bus.req0_data  = d0;
        bus.req1_valid = v1;
        bus.req1_addr  = a1;
        bus.req1_data  = d1;
        #1;
        check("req0_ready", 32'(bus.req0_ready), 32'(er0));
        check("req1_ready", 32'(bus.req1_ready), 32'(er1));
        if (push) exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic sweep(input int n, input logic hold_valid);
        for (int i = 1; i <= n; i++) begin
            step(hold_valid, 5'd3, 32'h1111, hold_valid, 5'd4, 32'h2222, 1'b0, 1'b0,
                 1'b1, '{1'b1, 5'(i), 32'h0, (i == 31)});
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rf_wen"}, 32'(rf_wen), 32'h0);
        check({tag, "_rf_waddr"}, 32'(rf_waddr), 32'h0);
        check({tag, "_rf_wdata"}, rf_wdata, 32'h0);
        check({tag, "_init_done"}, 32'(init_done), 32'h0);
    endtask

    // Monitor: compares the registered write port one step after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rf_wen", 32'(rf_wen), 32'(e.wen));
                check("rf_waddr", 32'(rf_waddr), 32'(e.waddr));
                check("rf_wdata", rf_wdata, e.wdata);
                check("init_done", 32'(init_done), 32'(e.done));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst            = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req0_addr  = '0;
        bus.req0_data  = '0;
        bus.req1_valid = 1'b0;
        bus.req1_addr  = '0;
        bus.req1_data  = '0;

        #12;
        check_reset_state("reset");
        @(negedge clk);
        rst = 1'b0;

        // Clear sweep with both requesters waiting: readies must stay low.
        sweep(31, 1'b1);

        // Contention: req0 wins first, then strict alternation.
        step(1, 5'd3, 32'hA0, 1, 5'd7, 32'hB0, 1, 0, 1, '{1'b1, 5'd3, 32'hA0, 1'b1});
        step(1, 5'd4, 32'hA1, 1, 5'd7, 32'hB0, 0, 1, 1, '{1'b1, 5'd7, 32'hB0, 1'b1});
        step(1, 5'd4, 32'hA1, 1, 5'd8, 32'hB1, 1, 0, 1, '{1'b1, 5'd4, 32'hA1, 1'b1});
        step(1, 5'd5, 32'hA2, 1, 5'd8, 32'hB1, 0, 1, 1, '{1'b1, 5'd8, 32'hB1, 1'b1});

        // Idle cycle: write enable drops, address/data hold.
        step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 1, '{1'b0, 5'd8, 32'hB1, 1'b1});

        // Single requesters are granted immediately regardless of last grant.
        step(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 1, 0, 1, '{1'b1, 5'd5, 32'hDEADBEEF, 1'b1});
        step(0, 5'd0, 32'h0, 1, 5'd9, 32'h55, 0, 1, 1, '{1'b1, 5'd9, 32'h55, 1'b1});
        step(1, 5'd10, 32'h66, 0, 5'd0, 32'h0, 1, 0, 1, '{1'b1, 5'd10, 32'h66, 1'b1});

        // Write to register 0 is accepted but suppressed.
        step(0, 5'd0, 32'h0, 1, 5'd0, 32'h1234, 0, 1, 1, '{1'b0, 5'd0, 32'h1234, 1'b1});

        // Contention after req1 won last: req0 goes first.
        step(1, 5'd31, 32'hFFFFFFFF, 1, 5'd2, 32'h22, 1, 0, 1, '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1});
        step(1, 5'd12, 32'h77, 1, 5'd2, 32'h22, 0, 1, 1, '{1'b1, 5'd2, 32'h22, 1'b1});

        // In-flight write, then asynchronous reset mid-cycle.
        step(1, 5'd6, 32'hCAFE, 0, 5'd0, 32'h0, 1, 0, 1, '{1'b1, 5'd6, 32'hCAFE, 1'b1});
        bus.req0_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("run_rst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Partial sweep to address 17, reset, then a full restart.
        sweep(17, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("init_rst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sweep(31, 1'b0);

        // last_grant was reset: req0 wins the first contention again.
        step(1, 5'd13, 32'h13, 1, 5'd14, 32'h14, 1, 0, 1, '{1'b1, 5'd13, 32'h13, 1'b1});
        step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 1, '{1'b0, 5'd13, 32'h13, 1'b1});

        @(posedge clk);
        #2;
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
